// File: rtl/cdc_toggle_pulse_array_if.sv
// Event-link bundle between the toggle CDC receiver and its consumer.
// The source-side toggles and the consumer handshake travel together, so one
// interface carries both; clk and rst stay outside as plain ports.
interface cdc_toggle_pulse_array_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 3
);
  logic [CHANNELS-1:0]       toggle;
  logic [CHANNELS-1:0]       ready;
  logic [CHANNELS-1:0]       clr_overflow;
  logic [CHANNELS-1:0]       pulse;
  logic [CHANNELS-1:0]       valid;
  logic [CHANNELS*CNT_W-1:0] pending;
  logic [CHANNELS-1:0]       overflow;
  logic [CHANNELS-1:0]       ack_toggle;

  // Environment side: drives toggles and consumer controls, observes events.
  modport master (
    output toggle, ready, clr_overflow,
    input  pulse, valid, pending, overflow, ack_toggle
  );

  // Receiver side: the cdc_toggle_pulse_array itself.
  modport slave (
    input  toggle, ready, clr_overflow,
    output pulse, valid, pending, overflow, ack_toggle
  );
endinterface

// File: rtl/cdc_toggle_pulse_array.sv
// Receive side of a multi-channel toggle CDC event link.
// Each channel synchronises an asynchronous toggle, converts every level change
// into a one-cycle pulse, queues events in a saturating counter drained by a
// valid/ready handshake, and returns the synchronised level as an ack toggle.
module cdc_toggle_pulse_array #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3
) (
  input logic                     clk,
  input logic                     rst,
  cdc_toggle_pulse_array_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [CHANNELS-1:0][SYNC_STAGES-1:0] r_sync;
  logic [CHANNELS-1:0]                  r_out_toggle;
  logic [CHANNELS-1:0][CNT_W-1:0]       r_pending;
  logic [CHANNELS-1:0]                  r_overflow;

  logic [CHANNELS-1:0]                  w_s_toggle;
  logic [CHANNELS-1:0]                  w_pulse;
  logic [CHANNELS-1:0]                  w_valid;
  logic [CHANNELS-1:0]                  w_pop;
  logic [CHANNELS-1:0][CNT_W-1:0]       w_pending_next;
  logic [CHANNELS-1:0]                  w_overflow_next;

  // Synchroniser chains: toggle[i] enters stage 0 and shifts toward the last stage.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], bus.toggle[i]};
      end
    end
  end

  // Last synchroniser stage per channel and the occupancy flag of each counter.
  always_comb begin
    w_s_toggle = '0;
    w_valid    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_s_toggle[i] = r_sync[i][SYNC_STAGES-1];
      w_valid[i]    = (r_pending[i] != '0);
    end
  end

  assign w_pulse = w_s_toggle ^ r_out_toggle;
  assign w_pop   = w_valid & bus.ready;

  // Edge-detect register; its value doubles as the acknowledge toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_toggle <= '0;
    end else begin
      r_out_toggle <= w_s_toggle;
    end
  end

  // Counter and overflow update: push saturates, push+pop cancels, set beats clear.
  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_pending_next  = r_pending;
    w_overflow_next = r_overflow & ~bus.clr_overflow;
    for (int i = 0; i < CHANNELS; i++) begin
      unique case ({w_pulse[i], w_pop[i]})
        2'b10: begin
          if (r_pending[i] == MAX_CNT) begin
            w_overflow_next[i] = 1'b1;
          end else begin
            w_pending_next[i] = r_pending[i] + ONE_CNT;
          end
        end
        2'b01:   w_pending_next[i] = r_pending[i] - ONE_CNT;
        default: w_pending_next[i] = r_pending[i];
      endcase
    end
  end

  // Pending counters and sticky overflow flags.
  // NOTE: reset clears queued events too, so a reset mid-operation discards
  // anything not yet drained rather than replaying stale events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= '0;
      r_overflow <= '0;
    end else begin
      r_pending  <= w_pending_next;
      r_overflow <= w_overflow_next;
    end
  end

  assign bus.pulse      = w_pulse;
  assign bus.valid      = w_valid;
  assign bus.pending    = r_pending;
  assign bus.overflow   = r_overflow;
  assign bus.ack_toggle = r_out_toggle;

endmodule

// File: tb/tb_cdc_toggle_pulse_array.sv
// Directed bench for cdc_toggle_pulse_array at default parameters.
// A table of per-cycle vectors covers single events and accumulate/drain;
// hand-written sequences cover saturation, overflow clear and mid-run reset.
module tb_cdc_toggle_pulse_array;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int CW = 3;

  logic clk;
  logic rst;

  cdc_toggle_pulse_array_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  cdc_toggle_pulse_array #(
    .CHANNELS   (CH),
    .SYNC_STAGES(SS),
    .CNT_W      (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  tog;
    logic [3:0]  rdy;
    logic [3:0]  e_pulse;
    logic [3:0]  e_valid;
    logic [11:0] e_pend;
    logic [3:0]  e_ack;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] tog, input logic [3:0] rdy,
                              input logic [3:0] p, input logic [3:0] v,
                              input logic [11:0] pend, input logic [3:0] ack);
    vec_t r;
    r.tog = tog; r.rdy = rdy; r.e_pulse = p; r.e_valid = v;
    r.e_pend = pend; r.e_ack = ack;
    return r;
  endfunction

  // Flip one channel's toggle and let it fully propagate into the counter.
  task automatic send_event(input int ch);
    bus.toggle[ch] = ~bus.toggle[ch];
    repeat (SS + 2) step();
  endtask

  logic [3:0] pulse_seen;
  int         ch3_pulses;

  initial begin
    rst              = 1'b1;
    bus.toggle       = '0;
    bus.ready        = '0;
    bus.clr_overflow = '0;

    // Each row: apply inputs, one edge, then compare (overflow stays 0 throughout).
    vecs[0]  = mk(4'h1, 4'h0, 4'h0, 4'h0, 12'h000, 4'h0);
    vecs[1]  = mk(4'h1, 4'h0, 4'h1, 4'h0, 12'h000, 4'h0);
    vecs[2]  = mk(4'h1, 4'h0, 4'h0, 4'h1, 12'h001, 4'h1);
    vecs[3]  = mk(4'h1, 4'h1, 4'h0, 4'h0, 12'h000, 4'h1);
    vecs[4]  = mk(4'h5, 4'h0, 4'h0, 4'h0, 12'h000, 4'h1);
    vecs[5]  = mk(4'h5, 4'h0, 4'h4, 4'h0, 12'h000, 4'h1);
    vecs[6]  = mk(4'h5, 4'h0, 4'h0, 4'h4, 12'h040, 4'h5);
    vecs[7]  = mk(4'h1, 4'h0, 4'h0, 4'h4, 12'h040, 4'h5);
    vecs[8]  = mk(4'h1, 4'h0, 4'h4, 4'h4, 12'h040, 4'h5);
    vecs[9]  = mk(4'h1, 4'h0, 4'h0, 4'h4, 12'h080, 4'h1);
    vecs[10] = mk(4'h5, 4'h0, 4'h0, 4'h4, 12'h080, 4'h1);
    vecs[11] = mk(4'h5, 4'h0, 4'h4, 4'h4, 12'h080, 4'h1);
    vecs[12] = mk(4'h5, 4'h0, 4'h0, 4'h4, 12'h0C0, 4'h5);
    vecs[13] = mk(4'h5, 4'h4, 4'h0, 4'h4, 12'h080, 4'h5);
    vecs[14] = mk(4'h5, 4'h4, 4'h0, 4'h4, 12'h040, 4'h5);
    vecs[15] = mk(4'h5, 4'h4, 4'h0, 4'h0, 12'h000, 4'h5);
    vecs[16] = mk(4'h5, 4'hF, 4'h0, 4'h0, 12'h000, 4'h5);

    // Reset state.
    #3;
    check("rst_pulse",    32'(bus.pulse),      32'h0);
    check("rst_valid",    32'(bus.valid),      32'h0);
    check("rst_pending",  32'(bus.pending),    32'h0);
    check("rst_overflow", 32'(bus.overflow),   32'h0);
    check("rst_ack",      32'(bus.ack_toggle), 32'h0);
    repeat (2) step();
    rst = 1'b0;
    pulse_seen = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      pulse_seen |= bus.pulse;
    end
    check("idle_pulse",   32'(pulse_seen),  32'h0);
    check("idle_pending", 32'(bus.pending), 32'h0);

    // Table-driven single-event and accumulate/drain vectors.
    for (int k = 0; k < 17; k++) begin
      bus.toggle = vecs[k].tog;
      bus.ready  = vecs[k].rdy;
      step();
      check($sformatf("vec%0d_pulse", k),    32'(bus.pulse),      32'(vecs[k].e_pulse));
      check($sformatf("vec%0d_valid", k),    32'(bus.valid),      32'(vecs[k].e_valid));
      check($sformatf("vec%0d_pending", k),  32'(bus.pending),    32'(vecs[k].e_pend));
      check($sformatf("vec%0d_ack", k),      32'(bus.ack_toggle), 32'(vecs[k].e_ack));
      check($sformatf("vec%0d_overflow", k), 32'(bus.overflow),   32'h0);
    end
    bus.ready = '0;

    // Saturation on ch1: seven events fill, the eighth is lost.
    for (int k = 0; k < 7; k++) send_event(1);
    check("sat7_pending",  32'(bus.pending[5:3]), 32'd7);
    check("sat7_overflow", 32'(bus.overflow[1]),  32'd0);
    send_event(1);
    check("sat8_pending",  32'(bus.pending[5:3]), 32'd7);
    check("sat8_overflow", 32'(bus.overflow),     32'h2);

    // Clear overflow.
    bus.clr_overflow[1] = 1'b1;
    step();
    bus.clr_overflow[1] = 1'b0;
    check("clr_overflow", 32'(bus.overflow[1]), 32'd0);

    // Pulse at full together with clear: the set must win.
    bus.toggle[1] = ~bus.toggle[1];
    repeat (SS) step();
    check("setclr_pulse", 32'(bus.pulse), 32'h2);
    bus.clr_overflow[1] = 1'b1;
    step();
    bus.clr_overflow[1] = 1'b0;
    check("setclr_overflow", 32'(bus.overflow[1]),  32'd1);
    check("setclr_pending",  32'(bus.pending[5:3]), 32'd7);
    step();

    // Simultaneous push and pop at full: count and overflow hold.
    bus.toggle[1] = ~bus.toggle[1];
    repeat (SS) step();
    check("pushpop_pulse", 32'(bus.pulse), 32'h2);
    bus.ready[1] = 1'b1;
    step();
    bus.ready[1] = 1'b0;
    check("pushpop_pending",  32'(bus.pending[5:3]), 32'd7);
    check("pushpop_overflow", 32'(bus.overflow[1]),  32'd1);
    check("pushpop_valid",    32'(bus.valid[1]),     32'd1);
    step();

    // Drain ch1 down to four pending.
    bus.ready[1] = 1'b1;
    repeat (3) step();
    bus.ready[1] = 1'b0;
    check("drain_pending", 32'(bus.pending[5:3]), 32'd4);

    // Reset mid-operation with toggle[3] held high.
    rst        = 1'b1;
    bus.toggle = 4'b1000;
    #1;
    check("midrst_pending",  32'(bus.pending),    32'h0);
    check("midrst_overflow", 32'(bus.overflow),   32'h0);
    check("midrst_valid",    32'(bus.valid),      32'h0);
    check("midrst_ack",      32'(bus.ack_toggle), 32'h0);
    check("midrst_pulse",    32'(bus.pulse),      32'h0);
    repeat (2) step();
    rst = 1'b0;
    pulse_seen = '0;
    ch3_pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      pulse_seen |= bus.pulse;
      if (bus.pulse[3]) ch3_pulses++;
    end
    check("post_rst_ch3_pulses", 32'(ch3_pulses),     32'd1);
    check("post_rst_pulse_mask", 32'(pulse_seen),     32'h8);
    check("post_rst_pending",    32'(bus.pending),    32'h200);
    check("post_rst_valid",      32'(bus.valid),      32'h8);
    check("post_rst_ack",        32'(bus.ack_toggle), 32'h8);
    check("post_rst_overflow",   32'(bus.overflow),   32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
